// File: rtl/regfile_pkg.sv
// Shared types for the Argon register file and its bus sequencer: word/index
// widths, request opcodes, bus command codes, sequencer states and select packing.
package regfile_pkg;

    localparam int WORD_WIDTH  = 16;
    localparam int INDEX_WIDTH = 3;
    localparam int SEL_WIDTH   = 3 * INDEX_WIDTH;

    typedef logic [WORD_WIDTH-1:0]  word_t;
    typedef logic [INDEX_WIDTH-1:0] idx_t;
    typedef logic [SEL_WIDTH-1:0]   sel_t;

    typedef enum logic [1:0] {
        OP_READ     = 2'd0,
        OP_WRITE    = 2'd1,
        OP_WRITE_RV = 2'd2,
        OP_WRITE_SP = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        COM_NOP      = 3'd0,
        COM_LATCHSEL = 3'd1,
        COM_READA    = 3'd2,
        COM_READB    = 3'd3,
        COM_LATCHC   = 3'd4,
        COM_LATCHRV  = 3'd5,
        COM_LATCHSP  = 3'd6
    } com_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEL  = 3'd1,
        ST_RDA  = 3'd2,
        ST_RDB  = 3'd3,
        ST_WR   = 3'd4,
        ST_RESP = 3'd5
    } seq_state_t;

    function automatic sel_t pack_triple(input idx_t a, input idx_t b, input idx_t c);
        return {c, b, a};
    endfunction

    function automatic word_t pack_sel(input idx_t a, input idx_t b, input idx_t c);
        return {{(WORD_WIDTH - SEL_WIDTH){1'b0}}, pack_triple(a, b, c)};
    endfunction

endpackage

// File: rtl/argon_bus_if.sv
// Command bus between the register-file sequencer (initiator) and the Argon
// register file (target).
interface argon_bus_if;
    import regfile_pkg::*;

    logic  i_valid;
    com_t  command;
    word_t i_data;
    logic  o_valid;
    word_t o_data;

    modport initiator (output i_valid, output command, output i_data,
                       input  o_valid, input  o_data);
    modport target    (input  i_valid, input  command, input  i_data,
                       output o_valid, output o_data);
endinterface

// File: rtl/argon_regfile_seq.sv
// Turns core operand-read / write-back requests into register-file bus command
// sequences. Define ARGON_REGSEQ_SELCACHE_EN to skip LATCHSEL on a repeated select triple.
module argon_regfile_seq
    import regfile_pkg::*;
(
    input  logic   i_Clk,
    input  logic   i_Reset,
    input  logic   i_req_valid,
    output logic   o_req_ready,
    input  op_t    i_req_op,
    input  idx_t   i_sel_a,
    input  idx_t   i_sel_b,
    input  idx_t   i_sel_c,
    input  word_t  i_wb_data,
    output logic   o_rsp_valid,
    input  logic   i_rsp_ready,
    output word_t  o_rsp_a,
    output word_t  o_rsp_b,
    output logic   o_rsp_err,
    argon_bus_if.initiator bus_if
);

    seq_state_t state_q,   state_d;
    op_t        op_q,      op_d;
    idx_t       sel_a_q,   sel_a_d;
    idx_t       sel_b_q,   sel_b_d;
    idx_t       sel_c_q,   sel_c_d;
    word_t      wb_data_q, wb_data_d;
    word_t      rsp_a_q,   rsp_a_d;
    word_t      rsp_b_q,   rsp_b_d;
    logic       err_q,     err_d;
    logic       accept_s;
    logic       skip_sel_s;

`ifdef ARGON_REGSEQ_SELCACHE_EN
    sel_t last_sel_q, last_sel_d;
    logic sel_vld_q,  sel_vld_d;

    assign skip_sel_s = sel_vld_q && (pack_triple(i_sel_a, i_sel_b, i_sel_c) == last_sel_q);
`else
    assign skip_sel_s = 1'b0;
`endif

    assign accept_s = (state_q == ST_IDLE) && i_req_valid;

    // Sequencer next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    case (i_req_op)
                        OP_READ:     state_d = skip_sel_s ? ST_RDA : ST_SEL;
                        OP_WRITE:    state_d = skip_sel_s ? ST_WR  : ST_SEL;
                        OP_WRITE_RV: state_d = ST_WR;
                        OP_WRITE_SP: state_d = ST_WR;
                        default:     state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEL:  state_d = (op_q == OP_READ) ? ST_RDA : ST_WR;
            ST_RDA:  state_d = ST_RDB;
            ST_RDB:  state_d = ST_RESP;
            ST_WR:   state_d = ST_RESP;
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture, operand capture and error tracking
    always_comb begin
        op_d      = op_q;
        sel_a_d   = sel_a_q;
        sel_b_d   = sel_b_q;
        sel_c_d   = sel_c_q;
        wb_data_d = wb_data_q;
        rsp_a_d   = rsp_a_q;
        rsp_b_d   = rsp_b_q;
        err_d     = err_q;
`ifdef ARGON_REGSEQ_SELCACHE_EN
        last_sel_d = last_sel_q;
        sel_vld_d  = sel_vld_q;
`endif
        if (accept_s) begin
            op_d      = i_req_op;
            sel_a_d   = i_sel_a;
            sel_b_d   = i_sel_b;
            sel_c_d   = i_sel_c;
            wb_data_d = i_wb_data;
        end else begin
            op_d      = op_q;
        end
        case (state_q)
            ST_SEL: begin
`ifdef ARGON_REGSEQ_SELCACHE_EN
                last_sel_d = pack_triple(sel_a_q, sel_b_q, sel_c_q);
                sel_vld_d  = 1'b1;
`endif
            end
            ST_RDA: begin
                rsp_a_d = bus_if.o_data;
                err_d   = err_q | ~bus_if.o_valid;
            end
            ST_RDB: begin
                rsp_b_d = bus_if.o_data;
                err_d   = err_q | ~bus_if.o_valid;
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    err_d = 1'b0;
                end else begin
                    err_d = err_q;
                end
            end
            default: begin
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_READ;
            sel_a_q   <= {INDEX_WIDTH{1'b0}};
            sel_b_q   <= {INDEX_WIDTH{1'b0}};
            sel_c_q   <= {INDEX_WIDTH{1'b0}};
            wb_data_q <= {WORD_WIDTH{1'b0}};
            rsp_a_q   <= {WORD_WIDTH{1'b0}};
            rsp_b_q   <= {WORD_WIDTH{1'b0}};
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            sel_a_q   <= sel_a_d;
            sel_b_q   <= sel_b_d;
            sel_c_q   <= sel_c_d;
            wb_data_q <= wb_data_d;
            rsp_a_q   <= rsp_a_d;
            rsp_b_q   <= rsp_b_d;
            err_q     <= err_d;
        end
    end

`ifdef ARGON_REGSEQ_SELCACHE_EN
    // Last issued select triple
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            last_sel_q <= {SEL_WIDTH{1'b0}};
            sel_vld_q  <= 1'b0;
        end else begin
            last_sel_q <= last_sel_d;
            sel_vld_q  <= sel_vld_d;
        end
    end
`endif

    // Bus drive decoded from state and latched request only
    always_comb begin
        bus_if.i_valid = 1'b0;
        bus_if.command = COM_NOP;
        bus_if.i_data  = {WORD_WIDTH{1'b0}};
        case (state_q)
            ST_SEL: begin
                bus_if.i_valid = 1'b1;
                bus_if.command = COM_LATCHSEL;
                bus_if.i_data  = pack_sel(sel_a_q, sel_b_q, sel_c_q);
            end
            ST_RDA: bus_if.command = COM_READA;
            ST_RDB: bus_if.command = COM_READB;
            ST_WR: begin
                bus_if.i_valid = 1'b1;
                bus_if.i_data  = wb_data_q;
                case (op_q)
                    OP_WRITE_RV: bus_if.command = COM_LATCHRV;
                    OP_WRITE_SP: bus_if.command = COM_LATCHSP;
                    default:     bus_if.command = COM_LATCHC;
                endcase
            end
            default: begin
                bus_if.i_valid = 1'b0;
            end
        endcase
    end

    assign o_req_ready = (state_q == ST_IDLE);
    assign o_rsp_valid = (state_q == ST_RESP);
    assign o_rsp_a     = rsp_a_q;
    assign o_rsp_b     = rsp_b_q;
    assign o_rsp_err   = err_q;

endmodule
